// File: rtl/add8_seq_ctrl.sv
// Operand loader and result capture stage around an external 8-bit adder.
// Accepts A then B(+cin) on a byte stream, waits SETTLE_CYCLES, captures sum/cout/overflow.
module add8_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       cin_in,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       op_cin,
    input  logic [7:0] sum_in,
    input  logic       cout_in,
    output logic [7:0] res_sum,
    output logic       res_cout,
    output logic       res_ovf,
    output logic       res_valid,
    input  logic       res_ready
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        GET_A  = 2'd0,
        GET_B  = 2'd1,
        SETTLE = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic       op_cin_q, op_cin_d;
    logic [7:0] res_sum_q, res_sum_d;
    logic       res_cout_q, res_cout_d;
    logic       res_ovf_q, res_ovf_d;
    logic       res_valid_q, res_valid_d;

    // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
    function automatic logic ovf_f(input logic signed [7:0] a,
                                   input logic signed [7:0] b,
                                   input logic signed [7:0] s);
        return (a[7] == b[7]) && (s[7] != a[7]);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = res_valid_q;
        din_ready   = (state_q == GET_A) || (state_q == GET_B);

        if (clr) begin
            state_d     = GET_A;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (din_valid && din_ready) begin
                        op_a_d  = din;
                        state_d = GET_B;
                    end
                end
                GET_B: begin
                    if (din_valid && din_ready) begin
                        op_b_d   = din;
                        op_cin_d = cin_in;
                        cnt_d    = CNT_INIT;
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        res_sum_d   = sum_in;
                        res_cout_d  = cout_in;
                        res_ovf_d   = ovf_f(op_a_q, op_b_q, sum_in);
                        res_valid_d = 1'b1;
                        state_d     = RESULT;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RESULT: begin
                    if (res_valid_q && res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = GET_A;
                    end
                end
                default: state_d = GET_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GET_A;
            cnt_q       <= 4'd0;
            op_a_q      <= 8'h00;
            op_b_q      <= 8'h00;
            op_cin_q    <= 1'b0;
            res_sum_q   <= 8'h00;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_cin    = op_cin_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_add8_seq_ctrl.sv
// Bench for add8_seq_ctrl: two instances (settle 1 and 3) each driving a behavioural adder.
module tb_add8_seq_ctrl;

    localparam int SC0 = 1;
    localparam int SC1 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr       [2];
    logic [7:0] din       [2];
    logic       din_valid [2];
    logic       din_ready [2];
    logic       cin_in    [2];
    logic [7:0] op_a      [2];
    logic [7:0] op_b      [2];
    logic       op_cin    [2];
    logic [7:0] sum_in    [2];
    logic       cout_in   [2];
    logic [7:0] res_sum   [2];
    logic       res_cout  [2];
    logic       res_ovf   [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic       glitch    [2];

    int checks = 0;
    int errors = 0;
    logic [7:0] last_b [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_adder
        logic [8:0] full;
        assign full = {1'b0, op_a[g]} + {1'b0, op_b[g]} + {8'd0, op_cin[g]};
        assign {cout_in[g], sum_in[g]} = glitch[g] ? ~full : full;
    end

    add8_seq_ctrl #(.SETTLE_CYCLES(SC0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .cin_in(cin_in[0]), .op_a(op_a[0]), .op_b(op_b[0]),
        .op_cin(op_cin[0]), .sum_in(sum_in[0]), .cout_in(cout_in[0]), .res_sum(res_sum[0]),
        .res_cout(res_cout[0]), .res_ovf(res_ovf[0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0])
    );

    add8_seq_ctrl #(.SETTLE_CYCLES(SC1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .cin_in(cin_in[1]), .op_a(op_a[1]), .op_b(op_b[1]),
        .op_cin(op_cin[1]), .sum_in(sum_in[1]), .cout_in(cout_in[1]), .res_sum(res_sum[1]),
        .res_cout(res_cout[1]), .res_ovf(res_ovf[1]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1])
    );

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         gap;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned and signed integer sums.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        int u;
        int sa;
        int sb;
        int s;
        logic [8:0] uv;
        logic ov;
        u  = int'(a) + int'(b) + int'(c);
        sa = $signed(a);
        sb = $signed(b);
        s  = sa + sb + int'(c);
        ov = (s > 127) || (s < -128);
        uv = u[8:0];
        return {ov, uv};
    endfunction

    task automatic send_byte(input int k, input logic [7:0] v, input logic c);
        int guard;
        guard = 0;
        din[k] = v;
        cin_in[k] = c;
        din_valid[k] = 1'b1;
        while (!din_ready[k] && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("din_ready_timeout", 0, 1);
        tick();
        din_valid[k] = 1'b0;
    endtask

    task automatic load_and_wait(input int k, input logic [7:0] a, input logic [7:0] b,
                                 input logic c);
        int lat;
        send_byte(k, a, 1'b0);
        send_byte(k, b, c);
        check("op_b_after_B", op_b[k], b);
        check("op_a_after_B", op_a[k], a);
        last_b[k] = b;
        lat = 0;
        while (!res_valid[k] && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, (k == 0) ? SC0 : SC1);
    endtask

    task automatic consume(input int k, input logic [7:0] exp_s);
        res_ready[k] = 1'b1;
        tick();
        res_ready[k] = 1'b0;
        check("valid_drop", res_valid[k], 0);
        check("ready_back", din_ready[k], 1);
        check("sum_kept", res_sum[k], exp_s);
    endtask

    task automatic run_row(input int k, input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] s, input logic co, input logic ov, input int gap);
        load_and_wait(k, a, b, c);
        check("res_sum", res_sum[k], s);
        check("res_cout", res_cout[k], co);
        check("res_ovf", res_ovf[k], ov);
        for (int i = 0; i < gap; i++) begin
            din_valid[k] = 1'b1;
            din[k] = 8'($urandom);
            tick();
            check("hold_valid", res_valid[k], 1);
            check("hold_result", {res_sum[k], res_cout[k], res_ovf[k]}, {s, co, ov});
            check("hold_not_ready", din_ready[k], 0);
            check("hold_ops", {op_a[k], op_b[k]}, {a, b});
        end
        din_valid[k] = 1'b0;
        consume(k, s);
    endtask

    initial begin
        logic [9:0] m;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        int         rk;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            clr[k] = 1'b0; din[k] = 8'h00; din_valid[k] = 1'b0; cin_in[k] = 1'b0;
            res_ready[k] = 1'b0; glitch[k] = 1'b0; last_b[k] = 8'h00;
        end

        tbl[0] = '{0, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 0};
        tbl[1] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[2] = '{0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0};
        tbl[3] = '{0, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 5};
        tbl[4] = '{1, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 0};
        tbl[5] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 2};
        tbl[6] = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1};

        #12;
        for (int k = 0; k < 2; k++) begin
            check("rst_ops", {op_a[k], op_b[k], op_cin[k]}, 0);
            check("rst_res", {res_sum[k], res_cout[k], res_ovf[k], res_valid[k]}, 0);
        end
        rst_n = 1'b1;
        tick();
        check("rst_ready0", din_ready[0], 1);
        check("rst_ready1", din_ready[1], 1);

        for (int i = 0; i < 7; i++)
            run_row(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].co, tbl[i].ov,
                    tbl[i].gap);

        // Sum glitches and din traffic during SETTLE must not leak into the result.
        send_byte(1, 8'h9C, 1'b0);
        send_byte(1, 8'h47, 1'b0);
        for (int i = 0; i < 2; i++) begin
            glitch[1] = 1'b1;
            din_valid[1] = 1'b1;
            din[1] = 8'($urandom);
            tick();
            check("settle_not_ready", din_ready[1], 0);
            check("settle_ops", {op_a[1], op_b[1]}, {8'h9C, 8'h47});
            check("settle_no_valid", res_valid[1], 0);
        end
        glitch[1] = 1'b0;
        tick();
        check("glitch_valid", res_valid[1], 1);
        check("glitch_sum", {res_sum[1], res_cout[1], res_ovf[1]}, {8'hE3, 1'b0, 1'b0});
        din_valid[1] = 1'b0;
        consume(1, 8'hE3);
        last_b[1] = 8'h47;

        // clr alongside a B beat discards it.
        send_byte(0, 8'h11, 1'b0);
        din[0] = 8'h22;
        din_valid[0] = 1'b1;
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        din_valid[0] = 1'b0;
        check("clr_op_b", op_b[0], last_b[0]);
        check("clr_op_a", op_a[0], 8'h11);
        check("clr_ready", din_ready[0], 1);
        tick(); tick(); tick();
        check("clr_no_valid", res_valid[0], 0);
        m = model(8'h05, 8'h06, 1'b0);
        run_row(0, 8'h05, 8'h06, 1'b0, m[7:0], m[8], m[9], 0);

        // clr alongside a result transfer.
        load_and_wait(0, 8'h40, 8'h40, 1'b0);
        res_ready[0] = 1'b1;
        clr[0] = 1'b1;
        tick();
        res_ready[0] = 1'b0;
        clr[0] = 1'b0;
        check("clr_res_valid", res_valid[0], 0);
        check("clr_res_ready", din_ready[0], 1);
        check("clr_res_kept", {res_sum[0], res_ovf[0]}, {8'h80, 1'b1});

        // Asynchronous reset in the middle of SETTLE.
        send_byte(1, 8'hAA, 1'b0);
        send_byte(1, 8'h55, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ops", {op_a[1], op_b[1], op_cin[1]}, 0);
        check("arst_res", {res_sum[1], res_cout[1], res_ovf[1], res_valid[1]}, 0);
        check("arst_res0", {res_sum[0], res_valid[0]}, 0);
        tick();
        check("arst_held", res_valid[1], 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_ready", din_ready[1], 1);
        run_row(1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            rk = int'($urandom_range(1, 0));
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            m = model(ra, rb, rc);
            run_row(rk, ra, rb, rc, m[7:0], m[8], m[9], int'($urandom_range(3, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
